// File: rtl/arbiter_mem_pkg.sv
// rtl/arbiter_mem_pkg.sv - shared state encoding and default requester map for arbiter_for_mem_n
package arbiter_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam arb_state_e ARB_IDLE = IDLE;
  localparam arb_state_e ARB_BUSY = BUSY;

  // Default requester slots; index 0 carries the highest fixed priority.
  localparam int REQ_I_AREG   = 0;
  localparam int REQ_D_AREG   = 1;
  localparam int REQ_DOWNLOAD = 2;

endpackage

// File: rtl/arbiter_mem_pick.sv
// rtl/arbiter_mem_pick.sv - combinational circular priority picker starting at a given index
module arbiter_mem_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] v_req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int   cand;
  logic found;

  // Walk requesters from start_i upward, wrapping at NUM_REQ; the first set bit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(start_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && v_req_i[cand[IDX_W-1:0]]) begin
        found                        = 1'b1;
        idx_o                        = cand[IDX_W-1:0];
        onehot_o[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/arbiter_for_mem_n.sv
// rtl/arbiter_for_mem_n.sv - N-requester memory port arbiter with watchdog; ARB_MEM_ROUND_ROBIN_EN selects round-robin
module arbiter_for_mem_n
  import arbiter_mem_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         v_req,
  input  logic                       mem_access_done,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         v_m,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic               terr_q, terr_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   start_ptr;

  logic [NUM_REQ-1:0] ack_raw;
  logic [IDX_W-1:0]   gid_raw;
  logic               wd_fire;

`ifdef ARB_MEM_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  assign start_ptr = rr_ptr_q;

  // Advance the search start to just past each new winner, wrapping to 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB_IDLE && pick_any) begin
      rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign start_ptr = '0;
`endif

  arbiter_mem_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .v_req_i  (v_req),
    .start_i  (start_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Watchdog fires on the last allowed BUSY cycle unless done arrives in that same cycle.
  assign wd_fire = WD_EN && (state_q == ARB_BUSY) && !mem_access_done && (wd_cnt_q == WD_LAST);

  // Next-state and grant outputs: IDLE shows the live winner, BUSY holds the latched grant.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    wd_cnt_d = wd_cnt_q;
    terr_d   = 1'b0;
    ack_raw  = '0;
    gid_raw  = '0;
    case (state_q)
      ARB_IDLE: begin
        ack_raw = pick_onehot;
        gid_raw = pick_idx;
        if (pick_any) begin
          state_d  = ARB_BUSY;
          grant_d  = pick_idx;
          wd_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        ack_raw[grant_q] = 1'b1;
        gid_raw          = grant_q;
        if (mem_access_done) begin
          state_d = ARB_IDLE;
        end else if (wd_fire) begin
          state_d = ARB_IDLE;
          terr_d  = 1'b1;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant, watchdog and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      wd_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wd_cnt_q <= wd_cnt_d;
      terr_q   <= terr_d;
    end
  end

  // Outputs are masked while reset is held so a pending request cannot leak a grant.
  assign ack         = rst ? '0 : ack_raw;
  assign v_m         = ack;
  assign grant_id    = rst ? '0 : gid_raw;
  assign busy        = !rst && (state_q == ARB_BUSY);
  assign timeout_err = terr_q;

endmodule

// File: doc/arbiter_for_mem_n.md
# arbiter_for_mem_n

Parametrised N-requester memory-access arbiter for the communication-assist path. It sits between the local access sources (instruction/data miss registers, download engine, and any added sources) and the single memory port. It grants exactly one requester, and holds that grant until the memory signals completion or a watchdog expires. Priority is either fixed or round-robin, selected at compile time.

## Interface
- NUM_REQ, 3: number of requesters, ≥2. Index 0 is highest fixed priority. Default map: 0 = i_m_areg, 1 = d_m_areg, 2 = mem_download.
- TIMEOUT_CYCLES, 0: busy-cycle limit before forced release. 0 disables the watchdog.
- CNT_W, 8: watchdog counter width. Requires TIMEOUT_CYCLES < 2^CNT_W.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- v_req  in  NUM_REQ  request valid, one bit per requester, level held until acked.
- mem_access_done  in  1  memory completed the current access.
- ack  out  NUM_REQ  one-hot grant acknowledge to requesters.
- v_m  out  NUM_REQ  one-hot valid forwarded to the memory side. Always equal to ack.
- grant_id  out  $clog2(NUM_REQ)  index of the current or selected winner. 0 when none.
- busy  out  1  arbiter is in BUSY.
- timeout_err  out  1  one-cycle pulse, watchdog forced a release.

## Operation
- States: IDLE, BUSY (encoding in package).
- IDLE:
  - The winner is picked combinationally from v_req. ack/v_m are one-hot on the winner in the same cycle, giving zero-latency grant.
  - If any request is present: next state BUSY; grant_q ← winner.
  - With no request: outputs stay 0 and the state stays IDLE.
  - mem_access_done is ignored in IDLE.
- BUSY:
  - ack/v_m are one-hot on grant_q regardless of v_req.
  - On mem_access_done: next state IDLE. Outputs remain asserted during the done cycle.
- After release there is always at least one IDLE cycle before the next grant. No back-to-back grants.
- Fixed priority: lowest set index of v_req wins.
- Round-robin: the search starts at rr_ptr and wraps modulo NUM_REQ. On each grant, rr_ptr ← (winner+1) mod NUM_REQ, so the wrap from NUM_REQ-1 goes to 0.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt clears on entering BUSY and increments each BUSY cycle.
  - If wd_cnt == TIMEOUT_CYCLES-1 without done: release as if done.
  - timeout_err pulses high for the first IDLE cycle after the forced release.
  - If done and timeout coincide, done wins and there is no error pulse.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, grant_q=0, rr_ptr=0, wd_cnt=0, timeout_err=0.
  - ack, v_m, grant_id and busy are forced 0 while rst is high, even if v_req is set.
- Grant latency: 0 cycles from v_req in IDLE.
- Release latency: state is IDLE 1 cycle after the done edge.
- Minimum request-to-request turnaround: access length + 1 cycle.
- Reset asserted mid-BUSY: the access is abandoned and outputs drop immediately. No timeout_err.
- grant_id is combinational winner in IDLE and grant_q in BUSY.

## Configuration
- ARB_MEM_ROUND_ROBIN_EN defined: round-robin picker and rr_ptr register are compiled in.
- ARB_MEM_ROUND_ROBIN_EN undefined: fixed priority by index, and rr_ptr does not exist.
- Both builds use identical ports.

## Structure
- Package arbiter_mem_pkg:
  - state typedef {IDLE, BUSY}
  - ARB_IDLE/ARB_BUSY constants
  - default requester index constants (REQ_I_AREG=0, REQ_D_AREG=1, REQ_DOWNLOAD=2).
- Sub-module arbiter_mem_pick: pure combinational picker.
  - Inputs: v_req, start pointer.
  - Outputs: one-hot winner, index, any.
  - The fixed build ties the start pointer to 0.

## Test plan
- NUM_REQ=3 fixed, v_req=3'b111 in IDLE → same cycle ack=3'b001, grant_id=0. The next cycle has busy=1; done after 4 cycles returns the state to IDLE one cycle later.
- Round-robin, v_req held 3'b111 with done 2 cycles after each grant → grant order 0,1,2,0. Exactly one IDLE cycle separates each grant.
- BUSY on index 1, v_req changes to 3'b100 → ack stays 3'b010 until done.
- TIMEOUT_CYCLES=5, no done → forced release after 5 BUSY cycles, and timeout_err=1 for exactly one cycle. With done on the 5th cycle, there is no pulse.
- rst asserted mid-BUSY with v_req=3'b010 → ack=0 and busy=0 immediately. After deassert, the grant restarts from IDLE and rr_ptr=0.
- NUM_REQ=5 round-robin, rr_ptr=4, v_req=5'b00011 → the wrap yields winner 0.
